// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared pipeline types and constants for hazard, forwarding and stall control
package pipeline_pkg;
  localparam int REG_W = 5;
  typedef enum logic [1:0] {RUN, STALL, MEM_WAIT} state_t;
endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if: ID/EX/MEM hazard fields, dmem handshake and pipeline control outputs
interface hazard_stall_ctrl_if #(
  parameter int REG_W = pipeline_pkg::REG_W,
  parameter int CNT_W = 32
);
  logic [REG_W-1:0] rs_id, rt_id, dest_idex, dest_exmem;
  logic is_branch_id, branch_taken_id, reg_write_idex, mem_read_idex, mem_read_exmem;
  logic dmem_req, dmem_ack;
  logic pc_write, ifid_write, ifid_flush, idex_noop, pipe_freeze, mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  modport master (
    output rs_id, rt_id, dest_idex, dest_exmem, is_branch_id, branch_taken_id,
           reg_write_idex, mem_read_idex, mem_read_exmem, dmem_req, dmem_ack,
    input  pc_write, ifid_write, ifid_flush, idex_noop, pipe_freeze, mem_timeout, stall_cycles
  );
  modport slave (
    input  rs_id, rt_id, dest_idex, dest_exmem, is_branch_id, branch_taken_id,
           reg_write_idex, mem_read_idex, mem_read_exmem, dmem_req, dmem_ack,
    output pc_write, ifid_write, ifid_flush, idex_noop, pipe_freeze, mem_timeout, stall_cycles
  );
endinterface

// File: rtl/hazard_classify.sv
// hazard_classify: combinational detection of load-use and branch-operand hazards with stall length n
module hazard_classify #(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  input  logic             is_branch_id,
  input  logic [REG_W-1:0] dest_idex,
  input  logic             reg_write_idex,
  input  logic             mem_read_idex,
  input  logic [REG_W-1:0] dest_exmem,
  input  logic             mem_read_exmem,
  output logic             hit,
  output logic [1:0]       n
);
  logic m_ex, m_mem, n2, n1;
  assign m_ex  = dest_idex != '0 && (dest_idex == rs_id || (dest_idex == rt_id && rt_id != '0));
  assign m_mem = dest_exmem != '0 && (dest_exmem == rs_id || (dest_exmem == rt_id && rt_id != '0));
  assign n2 = is_branch_id && mem_read_idex && m_ex;
  assign n1 = (mem_read_idex && m_ex) || (is_branch_id && reg_write_idex && !mem_read_idex && m_ex) ||
              (is_branch_id && mem_read_exmem && m_mem);
  assign hit = n2 || n1;
  assign n = n2 ? 2'd2 : n1 ? 2'd1 : 2'd0;
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: front-end stall/flush sequencing, back-end freeze on dmem waits, stall counter and timeout flag
module hazard_stall_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_W       = pipeline_pkg::REG_W,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input logic clk,
  input logic rst_n,
  hazard_stall_ctrl_if.slave bus
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  state_t state, ret, nxt, eff;
  logic [1:0] cnt, cnt_nxt, n;
  logic hit, frz, stall, flush, tmo;
  logic [WW-1:0] wait_cnt;
  logic [CNT_W-1:0] sc;
  hazard_classify #(.REG_W(REG_W)) u_cls (
    .rs_id(bus.rs_id), .rt_id(bus.rt_id), .is_branch_id(bus.is_branch_id),
    .dest_idex(bus.dest_idex), .reg_write_idex(bus.reg_write_idex), .mem_read_idex(bus.mem_read_idex),
    .dest_exmem(bus.dest_exmem), .mem_read_exmem(bus.mem_read_exmem), .hit(hit), .n(n)
  );
  // while waiting, the saved state drives behaviour so the ack cycle acts as if never frozen
  always_comb begin
    eff = (state == MEM_WAIT) ? ret : state;
    frz = rst_n && ((bus.dmem_req && !bus.dmem_ack) || (state == MEM_WAIT && !bus.dmem_ack));
    stall = rst_n && !frz && (eff == STALL || hit);
    flush = rst_n && !frz && eff == RUN && !hit && bus.is_branch_id && bus.branch_taken_id;
    nxt = frz ? MEM_WAIT : (eff == STALL) ? ((cnt == 2'd1) ? RUN : STALL) : (hit && n == 2'd2) ? STALL : RUN;
    cnt_nxt = frz ? cnt : (eff == STALL) ? cnt - 2'd1 : hit ? n - 2'd1 : cnt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      ret <= RUN;
      cnt <= '0;
      wait_cnt <= '0;
      tmo <= 1'b0;
      sc <= '0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
      if (frz && state != MEM_WAIT) ret <= state;
      wait_cnt <= !frz ? '0 : (wait_cnt == WW'(MEM_TIMEOUT)) ? wait_cnt : wait_cnt + WW'(1);
      if (frz && wait_cnt == WW'(MEM_TIMEOUT - 1)) tmo <= 1'b1;
      if ((stall || frz) && ~&sc) sc <= sc + CNT_W'(1);
    end
  end
  assign bus.pc_write = !(stall || frz);
  assign bus.ifid_write = !(stall || frz);
  assign bus.ifid_flush = flush;
  assign bus.idex_noop = stall;
  assign bus.pipe_freeze = frz;
  assign bus.stall_cycles = sc;
  assign bus.mem_timeout = tmo;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed and random stimulus checked against a cycle-count reference model
module tb_hazard_stall_ctrl;
  localparam int TMO = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int rem = 0;
  int wcnt = 0;
  bit waiting = 1'b0;
  bit tmo = 1'b0;
  int unsigned sc = 0;

  hazard_stall_ctrl_if bus();
  hazard_stall_ctrl #(.REG_W(5), .CNT_W(32), .MEM_TIMEOUT(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit uses(input logic [4:0] x);
    return x != 0 && (x == bus.rs_id || (x == bus.rt_id && bus.rt_id != 0));
  endfunction

  // stall cycles demanded by the instruction in ID: largest of all hazard classes that apply
  function automatic int need();
    int k = 0;
    if (bus.mem_read_idex && uses(bus.dest_idex)) k = 1;
    if (bus.is_branch_id && bus.reg_write_idex && !bus.mem_read_idex && uses(bus.dest_idex)) k = 1;
    if (bus.is_branch_id && bus.mem_read_exmem && uses(bus.dest_exmem)) k = 1;
    if (bus.is_branch_id && bus.mem_read_idex && uses(bus.dest_idex)) k = 2;
    return k;
  endfunction

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic br, input logic tk,
                       input logic [4:0] dex, input logic rw, input logic mr, input logic [4:0] dmm,
                       input logic mrm, input logic req, input logic ack);
    bus.rs_id = rs; bus.rt_id = rt; bus.is_branch_id = br; bus.branch_taken_id = tk;
    bus.dest_idex = dex; bus.reg_write_idex = rw; bus.mem_read_idex = mr;
    bus.dest_exmem = dmm; bus.mem_read_exmem = mrm; bus.dmem_req = req; bus.dmem_ack = ack;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // one clock cycle: settle, compare against model, advance model, cross the edge
  task automatic step(input string tag);
    bit f, st, fl;
    int k;
    #3;
    f = (bus.dmem_req && !bus.dmem_ack) || (waiting && !bus.dmem_ack);
    st = 1'b0;
    fl = 1'b0;
    if (!f) begin
      if (rem > 0) begin
        st = 1'b1;
        rem--;
      end else begin
        k = need();
        if (k > 0) begin
          st = 1'b1;
          rem = k - 1;
        end else fl = bus.is_branch_id && bus.branch_taken_id;
      end
    end
    chk({tag, ".ctl"}, {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_noop, bus.pipe_freeze},
        {!(f || st), !(f || st), fl, st, f});
    chk({tag, ".stall_cycles"}, bus.stall_cycles, sc);
    chk({tag, ".mem_timeout"}, bus.mem_timeout, tmo);
    waiting = f;
    if (f) begin
      if (wcnt < TMO) wcnt++;
      if (wcnt == TMO) tmo = 1'b1;
    end else wcnt = 0;
    if (f || st) sc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    chk({tag, ".rst_ctl"}, {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_noop, bus.pipe_freeze}, 5'b11000);
    chk({tag, ".rst_cnt"}, bus.stall_cycles, 0);
    chk({tag, ".rst_tmo"}, bus.mem_timeout, 0);
    rem = 0; wcnt = 0; waiting = 1'b0; tmo = 1'b0; sc = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
  endtask

  initial begin
    drive(8, 0, 1, 1, 8, 1, 1, 0, 0, 1, 0);
    #2;
    chk("por.ctl", {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_noop, bus.pipe_freeze}, 5'b11000);
    chk("por.cnt", bus.stall_cycles, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    step("idle");
    drive(8, 0, 0, 0, 8, 1, 1, 0, 0, 0, 0);
    step("lu0");
    idle();
    step("lu1");
    chk("lu.count", bus.stall_cycles, 1);
    do_reset("r1");
    drive(0, 9, 1, 0, 9, 1, 1, 0, 0, 0, 0);
    step("bl0");
    step("bl1");
    idle();
    step("bl2");
    chk("bl.count", bus.stall_cycles, 2);
    drive(0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    step("r0a");
    step("r0b");
    chk("r0.count", bus.stall_cycles, 2);
    do_reset("r2");
    drive(1, 2, 1, 1, 3, 1, 0, 4, 1, 0, 0);
    #2;
    chk("tb.flush", bus.ifid_flush, 1);
    chk("tb.pcw", bus.pc_write, 1);
    step("tb0");
    drive(1, 2, 1, 1, 1, 1, 0, 0, 0, 0, 0);
    #2;
    chk("tbh.flush", bus.ifid_flush, 0);
    chk("tbh.pcw", bus.pc_write, 0);
    step("tbh0");
    idle();
    step("tbh1");
    chk("tbh.count", bus.stall_cycles, 1);
    do_reset("r3");
    drive(0, 9, 1, 0, 9, 1, 1, 0, 0, 0, 0);
    step("ws0");
    drive(0, 9, 1, 0, 9, 1, 1, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step("ws_frz");
    drive(0, 9, 1, 0, 9, 1, 1, 0, 0, 1, 1);
    #2;
    chk("ws.ack_frz", bus.pipe_freeze, 0);
    chk("ws.ack_noop", bus.idex_noop, 1);
    step("ws_ack");
    idle();
    step("ws_end");
    chk("ws.count", bus.stall_cycles, 5);
    do_reset("r4");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < TMO - 1; i++) step("to_wait");
    chk("to.before", bus.mem_timeout, 0);
    step("to_last");
    chk("to.rise", bus.mem_timeout, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step("to_ack");
    idle();
    step("to_idle");
    chk("to.sticky", bus.mem_timeout, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("ar0");
    #2;
    chk("ar.frz", bus.pipe_freeze, 1);
    rst_n = 1'b0;
    #1;
    chk("ar.ctl", {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_noop, bus.pipe_freeze}, 5'b11000);
    chk("ar.count", bus.stall_cycles, 0);
    chk("ar.tmo", bus.mem_timeout, 0);
    rem = 0; wcnt = 0; waiting = 1'b0; tmo = 1'b0; sc = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    for (int i = 0; i < 400; i++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
      step("rnd");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Sequencing controller for the 5-stage MIPS pipeline's hazard resources: PC write enable, IF/ID write and flush, ID/EX bubble insertion, and a whole-pipe freeze.
- Detects load-use and branch-operand hazards in ID and holds the front end for the required number of cycles through an internal countdown FSM.
- Freezes the back end while a multi-cycle data-memory access is outstanding.
- Keeps a stall-cycle performance counter and a sticky memory-timeout flag.

Parameters:
- REG_W, 5, register-specifier width.
- CNT_W, 32, width of the stall performance counter.
- MEM_TIMEOUT, 16, wait cycles without dmem_ack before mem_timeout sets (must be at least 2).

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rs_id  in  REG_W  Rs of the instruction in ID.
- rt_id  in  REG_W  Rt of the instruction in ID.
- is_branch_id  in  1  ID holds a branch (beq/bne) that compares in ID.
- branch_taken_id  in  1  ID branch comparison result.
- dest_idex  in  REG_W  destination register of the instruction in EX.
- reg_write_idex  in  1  EX instruction writes the register file.
- mem_read_idex  in  1  EX instruction is a load.
- dest_exmem  in  REG_W  destination register of the instruction in MEM.
- mem_read_exmem  in  1  MEM instruction is a load.
- dmem_req  in  1  MEM stage is accessing data memory this cycle.
- dmem_ack  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register enable.
- ifid_flush  out  1  clear IF/ID (taken branch).
- idex_noop  out  1  zero the ID/EX control bits (bubble).
- pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
- stall_cycles  out  CNT_W  count of cycles with pc_write=0.
- mem_timeout  out  1  sticky error flag.

Behaviour:
- Reset (async, rst_n=0): state RUN, stall counter 0, wait counter 0, stall_cycles 0, mem_timeout 0.
- Output values during reset: pc_write=1, ifid_write=1, ifid_flush=0, idex_noop=0, pipe_freeze=0.
- Outputs are combinational from state plus current inputs, so a stall takes effect in the cycle the hazard is detected (zero latency).
- Matching helper: match(x) = (x != 0) && (x == rs_id || (x == rt_id && rt_id != 0)). Register 0 never causes a hazard.
- Hazard classes, evaluated only in RUN while not frozen; N is the number of stall cycles:
  - Load-use: mem_read_idex && match(dest_idex) gives N=1.
  - Branch on a load in EX: is_branch_id && mem_read_idex && match(dest_idex) gives N=2. This takes precedence over load-use.
  - Branch on an ALU op in EX: is_branch_id && reg_write_idex && !mem_read_idex && match(dest_idex) gives N=1.
  - Branch on a load in MEM: is_branch_id && mem_read_exmem && match(dest_exmem) gives N=1.
  - If several classes hit, the maximum N applies.
- FSM states: RUN, STALL, MEM_WAIT.
- RUN:
  - A hazard detected: pc_write=0, ifid_write=0, idex_noop=1. Load count=N-1. Go to STALL if N-1>0, else stay in RUN.
  - No hazard and is_branch_id && branch_taken_id: ifid_flush=1 for that cycle.
- STALL:
  - Outputs are the same as a RUN stall: pc_write=0, ifid_write=0, idex_noop=1.
  - Hazard inputs are ignored.
  - Decrement count each cycle; return to RUN on the cycle count reaches 0.
  - ifid_flush is never asserted in STALL.
- MEM_WAIT:
  - Entered from any state when dmem_req && !dmem_ack.
  - This condition has highest priority over all hazard handling.
  - Outputs: pc_write=0, ifid_write=0, pipe_freeze=1, idex_noop=0, ifid_flush=0.
  - The stall count and the return state are preserved while waiting.
  - Exit on dmem_ack to the saved state.
  - The ack cycle itself is not frozen; normal outputs for the saved state apply in that cycle.
- Wait counter:
  - Increments every MEM_WAIT cycle and saturates at MEM_TIMEOUT.
  - mem_timeout sets when the wait counter reaches MEM_TIMEOUT, and clears only on reset.
  - The wait counter clears on exit from MEM_WAIT.
- stall_cycles increments in every cycle with pc_write=0 and saturates at all-ones.
- Reset asserted mid-stall or mid-wait returns immediately to the reset values.

Decomposition:
- Shared package (pipeline_pkg): FSM state enum (RUN, STALL, MEM_WAIT) and the REG_W constant, shared with the forwarding and hazard blocks.
- Sub-module hazard_classify: purely combinational. Takes the ID/EX/MEM fields and returns hazard_hit and N (2 bits).
- The FSM, counters and output decode stay in hazard_stall_ctrl.

Test Plan:
- Load-use: EX lw with dest_idex=8, mem_read_idex=1; ID add with rs_id=8.
  - Required: exactly 1 cycle of pc_write=0, ifid_write=0, idex_noop=1, then RUN; stall_cycles=1.
- Branch after load: EX lw with dest_idex=9; ID beq with rt_id=9.
  - Required: 2 consecutive stall cycles, then release; stall_cycles=2.
  - Repeat with dest=0 and rs_id=rt_id=0: no stall.
- Taken branch, no hazard: is_branch_id=1, branch_taken_id=1, no register matches.
  - Required: ifid_flush=1 for 1 cycle, pc_write=1.
  - With a simultaneous ALU-dependency hazard: ifid_flush=0 and 1 stall cycle.
- Memory wait during STALL: in the first cycle of a 2-cycle branch stall, hold dmem_req=1 with dmem_ack=0 for 3 cycles.
  - Required: pipe_freeze=1 for 3 cycles; then the remaining 1 stall cycle completes.
  - Required: stall_cycles=5.
- Timeout: dmem_req=1 with no ack for MEM_TIMEOUT=16 cycles.
  - Required: mem_timeout rises on the 16th wait cycle and stays 1 after the ack; clears only on rst_n=0.
- Async reset: assert rst_n=0 mid-freeze.
  - Required: outputs return to the reset values within the same cycle, with no clock edge needed; stall_cycles=0.
